timer_bank: RTL and testbench
=============================

TIMER_BANK -- requirements
Module: timer_bank

Interface
REQ-001 Parameter NUM_CH, default 8, number of independent timeout channels (1..32).
REQ-002 Parameter CNT_W, default 9, width of each channel counter and limit.
REQ-003 Parameter PRESCALE, default 1000, sb_clk cycles per slow tick (2..65535).
REQ-004 sb_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-low reset, sampled on rising sb_clk.
REQ-006 ch_en  input  NUM_CH  per-channel run enable; low holds the channel cleared.
REQ-007 ch_restart  input  NUM_CH  per-channel synchronous counter clear while enabled.
REQ-008 ch_base  input  NUM_CH  advance source: 0 = every sb_clk, 1 = prescaled tick.
REQ-009 ch_mode  input  NUM_CH  0 = one-shot sticky timeout, 1 = periodic auto-reload.
REQ-010 ch_limit  input  NUM_CH*CNT_W  channel i limit in bits [i*CNT_W +: CNT_W], sampled live.
REQ-011 tick_o  output  1  one-cycle pulse at each prescaled tick.
REQ-012 timeout  output  NUM_CH  registered level timeout, mode 0 only.
REQ-013 expired_p  output  NUM_CH  registered one-cycle pulse on each expiry event, both modes.

Function
REQ-014 Prescaler SHALL count 0..PRESCALE-1 free-running; tick asserted in the cycle the count equals PRESCALE-1, count then wraps to 0.
REQ-015 tick_o SHALL be the registered tick, i.e. high one cycle after the prescaler count equals PRESCALE-1.
REQ-016 Channel "advance" SHALL be 1 every cycle when ch_base=0, and equal to tick when ch_base=1.
REQ-017 ch_en=0 SHALL force cnt=0, timeout=0, expired_p=0 on the next edge, regardless of other inputs.
REQ-018 ch_restart=1 with ch_en=1 SHALL force cnt=0 and timeout=0 on the next edge; restart has priority over advance.
REQ-019 Channel with limit=0 SHALL never expire; cnt held at 0.
REQ-020 Expiry condition SHALL be cnt >= limit (limit != 0), so a limit lowered below cnt expires without wrap.
REQ-021 Mode 0: on advance with cnt < limit, cnt increments by 1; at cnt >= limit cnt holds (saturates, never wraps).
REQ-022 Mode 0: timeout SHALL be registered (ch_en & limit!=0 & cnt>=limit); high one edge after cnt reaches limit, stays high until en low, restart, or limit raised above cnt.
REQ-023 Mode 1: on advance with cnt >= limit, cnt SHALL reload to 1; otherwise increments; period = limit advances.
REQ-024 Mode 1: timeout SHALL stay 0.
REQ-025 expired_p SHALL pulse one cycle, one edge after the cycle in which cnt first satisfies cnt>=limit since last clear/reload; in mode 0 exactly once per clear.
REQ-026 Mode change while enabled SHALL take effect on the next edge with cnt unchanged.
REQ-027 Channels SHALL be fully independent; simultaneous expiries on several channels all reported same cycle.
REQ-028 Counter arithmetic SHALL be CNT_W-bit unsigned; no overflow reachable since increment stops at limit.

Reset
REQ-029 rst=0 at an edge SHALL clear prescaler, all cnt, tick_o, timeout, expired_p to 0, overriding all inputs.
REQ-030 Reset mid-count SHALL discard progress; counting resumes from 0 on the first edge with rst=1 and ch_en=1.

Verification
REQ-031 PRESCALE=4; ch0 mode0 base0 limit=14, en from cycle 0 -> cnt=14 after 14th edge, timeout and expired_p high after 15th edge; expired_p low next cycle; timeout held; en low -> timeout 0 next edge.
REQ-032 ch1 mode0 base1 limit=10, PRESCALE=4 -> tick_o every 4 cycles; timeout asserts within 40..44 cycles of enable.
REQ-033 ch2 mode1 base0 limit=3 -> expired_p high every 3rd cycle continuously, timeout stays 0; cnt sequence 1,2,3,1,2,3.
REQ-034 ch3 limit=10, restart at cnt=7 asserted together with advance -> cnt=0, timeout 10 advances later; limit=0 -> no expiry over 1000 cycles.
REQ-035 ch4 mode0 limit=50, cnt=20, limit rewritten to 5 -> timeout and expired_p next edge, cnt held at 20; limit back to 50 -> timeout drops, counting resumes.
REQ-036 rst low for 1 cycle while channels 0..7 mid-count and prescaler=2 -> all outputs 0, prescaler 0 next edge; first tick_o exactly PRESCALE cycles after release.

Source files
------------

// File: rtl/timer_bank_if.sv
// Channel control, limit and status bundle for timer_bank.
interface timer_bank_if #(
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned CNT_W  = 9
);
    logic [NUM_CH-1:0]       ch_en;
    logic [NUM_CH-1:0]       ch_restart;
    logic [NUM_CH-1:0]       ch_base;
    logic [NUM_CH-1:0]       ch_mode;
    logic [NUM_CH*CNT_W-1:0] ch_limit;
    logic                    tick_o;
    logic [NUM_CH-1:0]       timeout;
    logic [NUM_CH-1:0]       expired_p;

    modport master (
        output ch_en, ch_restart, ch_base, ch_mode, ch_limit,
        input  tick_o, timeout, expired_p
    );

    modport slave (
        input  ch_en, ch_restart, ch_base, ch_mode, ch_limit,
        output tick_o, timeout, expired_p
    );
endinterface

// File: rtl/timer_bank.sv
// Bank of independent timeout channels sharing one free-running prescaler.
module timer_bank #(
    parameter int unsigned NUM_CH   = 8,
    parameter int unsigned CNT_W    = 9,
    parameter int unsigned PRESCALE = 1000
) (
    input  logic        sb_clk,
    input  logic        rst,
    timer_bank_if.slave bus
);
    localparam int unsigned PRE_W = 16;

    logic [PRE_W-1:0]  presc_q, presc_d;
    logic              tick_c;
    logic              tick_q;
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] timeout_q, timeout_d;
    logic [NUM_CH-1:0] exp_q, exp_d;
    logic [NUM_CH-1:0] fired_q, fired_d;

    // Free-running 0..PRESCALE-1 counter; tick_c marks the wrap cycle.
    always_comb begin
        tick_c  = (presc_q == PRE_W'(PRESCALE - 1));
        presc_d = tick_c ? '0 : presc_q + PRE_W'(1);
    end

    // fired tracks that the current expiry has already been pulsed, so a
    // saturated or tick-waiting counter reports it only once.
    always_comb begin
        logic [CNT_W-1:0] lim;
        logic             hit;
        logic             adv;
        lim = '0;
        hit = 1'b0;
        adv = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i]     = '0;
            timeout_d[i] = 1'b0;
            exp_d[i]     = 1'b0;
            fired_d[i]   = 1'b0;
            lim = bus.ch_limit[i*CNT_W +: CNT_W];
            hit = bus.ch_en[i] && (lim != '0) && (cnt_q[i] >= lim);
            adv = bus.ch_base[i] ? tick_c : 1'b1;
            if (bus.ch_en[i] && !bus.ch_restart[i]) begin
                cnt_d[i]     = cnt_q[i];
                exp_d[i]     = hit && !fired_q[i];
                fired_d[i]   = hit;
                timeout_d[i] = hit && !bus.ch_mode[i];
                if (lim == '0) begin
                    cnt_d[i] = '0;
                end else if (adv) begin
                    if (!hit) begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end else if (bus.ch_mode[i]) begin
                        // Reload starts a new period; re-arm the pulse.
                        cnt_d[i]   = CNT_W'(1);
                        fired_d[i] = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge sb_clk) begin
        if (!rst) begin
            presc_q   <= '0;
            tick_q    <= 1'b0;
            timeout_q <= '0;
            exp_q     <= '0;
            fired_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            presc_q   <= presc_d;
            tick_q    <= tick_c;
            timeout_q <= timeout_d;
            exp_q     <= exp_d;
            fired_q   <= fired_d;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.tick_o    = tick_q;
    assign bus.timeout   = timeout_q;
    assign bus.expired_p = exp_q;
endmodule

// File: tb/tb_timer_bank.sv
// Directed self-checking bench for timer_bank with PRESCALE=4.
module tb_timer_bank;
    localparam int unsigned NCH = 8;
    localparam int unsigned CW  = 9;

    logic sb_clk = 1'b0;
    logic rst    = 1'b0;
    int   checks = 0;
    int   errors = 0;

    timer_bank_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();

    timer_bank #(.NUM_CH(NCH), .CNT_W(CW), .PRESCALE(4)) dut (
        .sb_clk (sb_clk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 sb_clk = ~sb_clk;

    task automatic step(input int n);
        repeat (n) @(posedge sb_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int i, input logic en, input logic mode,
                          input logic base, input int lim);
        bus.ch_en[i]               = en;
        bus.ch_mode[i]             = mode;
        bus.ch_base[i]             = base;
        bus.ch_restart[i]          = 1'b0;
        bus.ch_limit[i*CW +: CW]   = CW'(lim);
    endtask

    // Advance until tick_o is seen (prescaler then reads 0), bounded.
    task automatic sync_tick(input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            step(1);
            seen = bus.tick_o;
        end
        if (!seen) chk(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        bit acc;
        bus.ch_en      = '0;
        bus.ch_restart = '0;
        bus.ch_base    = '0;
        bus.ch_mode    = '0;
        bus.ch_limit   = '0;

        // Reset state
        step(2);
        chk("rst_tick", 32'(bus.tick_o), 32'd0);
        chk("rst_timeout", 32'(bus.timeout), 32'd0);
        chk("rst_expired", 32'(bus.expired_p), 32'd0);

        // ch0 one-shot, every clock, limit 14; prescaler ticks alongside
        rst = 1'b1;
        set_ch(0, 1'b1, 1'b0, 1'b0, 14);
        step(3);
        chk("tick_before_first", 32'(bus.tick_o), 32'd0);
        step(1);
        chk("tick_first", 32'(bus.tick_o), 32'd1);
        step(1);
        chk("tick_one_cycle", 32'(bus.tick_o), 32'd0);
        step(9);
        chk("ch0_timeout_at14", 32'(bus.timeout[0]), 32'd0);
        chk("ch0_exp_at14", 32'(bus.expired_p[0]), 32'd0);
        step(1);
        chk("ch0_timeout_at15", 32'(bus.timeout[0]), 32'd1);
        chk("ch0_exp_at15", 32'(bus.expired_p), 32'h01);
        step(1);
        chk("ch0_exp_drop", 32'(bus.expired_p[0]), 32'd0);
        step(5);
        chk("ch0_timeout_hold", 32'(bus.timeout[0]), 32'd1);
        chk("ch0_no_repulse", 32'(bus.expired_p[0]), 32'd0);
        bus.ch_en[0] = 1'b0;
        step(1);
        chk("ch0_en_low", 32'(bus.timeout[0]), 32'd0);

        // ch1 one-shot on prescaled tick, limit 10: enable right after a tick
        sync_tick("ch1_sync");
        set_ch(1, 1'b1, 1'b0, 1'b1, 10);
        step(40);
        chk("ch1_timeout_at40", 32'(bus.timeout[1]), 32'd0);
        step(1);
        chk("ch1_timeout_at41", 32'(bus.timeout[1]), 32'd1);
        chk("ch1_exp_at41", 32'(bus.expired_p), 32'h02);
        step(1);
        chk("ch1_exp_drop", 32'(bus.expired_p[1]), 32'd0);
        bus.ch_en[1] = 1'b0;
        step(1);

        // ch2 periodic, every clock, limit 3: pulse every third edge
        set_ch(2, 1'b1, 1'b1, 1'b0, 3);
        acc = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            chk($sformatf("ch2_exp_e%0d", k), 32'(bus.expired_p[2]),
                32'((k >= 4) && ((k - 4) % 3 == 0)));
            acc |= bus.timeout[2];
        end
        chk("ch2_timeout_zero", 32'(acc), 32'd0);
        bus.ch_en[2] = 1'b0;
        step(1);

        // ch3 restart at cnt=7, then limit 0 never expires
        set_ch(3, 1'b1, 1'b0, 1'b0, 10);
        step(7);
        bus.ch_restart[3] = 1'b1;
        step(1);
        bus.ch_restart[3] = 1'b0;
        step(10);
        chk("ch3_timeout_after10", 32'(bus.timeout[3]), 32'd0);
        step(1);
        chk("ch3_timeout_after11", 32'(bus.timeout[3]), 32'd1);
        bus.ch_limit[3*CW +: CW] = '0;
        step(1);
        chk("ch3_lim0_clears", 32'(bus.timeout[3]), 32'd0);
        acc = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            step(1);
            acc |= bus.timeout[3] | bus.expired_p[3];
        end
        chk("ch3_lim0_never", 32'(acc), 32'd0);
        bus.ch_en[3] = 1'b0;
        step(1);

        // ch4 limit lowered below cnt, then raised back
        set_ch(4, 1'b1, 1'b0, 1'b0, 50);
        step(20);
        bus.ch_limit[4*CW +: CW] = CW'(5);
        step(1);
        chk("ch4_lowered_timeout", 32'(bus.timeout[4]), 32'd1);
        chk("ch4_lowered_exp", 32'(bus.expired_p[4]), 32'd1);
        step(1);
        chk("ch4_exp_once", 32'(bus.expired_p[4]), 32'd0);
        bus.ch_limit[4*CW +: CW] = CW'(50);
        step(1);
        chk("ch4_raised_drop", 32'(bus.timeout[4]), 32'd0);
        step(29);
        chk("ch4_resume_cnt49", 32'(bus.timeout[4]), 32'd0);
        step(1);
        chk("ch4_resume_expire", 32'(bus.timeout[4]), 32'd1);
        chk("ch4_resume_exp", 32'(bus.expired_p[4]), 32'd1);
        bus.ch_en = '0;
        step(1);

        // All channels expire, reset with prescaler at 2, then resume together
        for (int i = 0; i < NCH; i++) set_ch(i, 1'b1, 1'b0, 1'b0, 5);
        step(8);
        sync_tick("rst_sync");
        step(2);
        chk("all_timeout_pre_rst", 32'(bus.timeout), 32'hFF);
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        chk("rst_mid_tick", 32'(bus.tick_o), 32'd0);
        chk("rst_mid_timeout", 32'(bus.timeout), 32'd0);
        chk("rst_mid_exp", 32'(bus.expired_p), 32'd0);
        acc = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(1);
            acc |= bus.tick_o;
        end
        chk("post_rst_no_early_tick", 32'(acc), 32'd0);
        step(1);
        chk("post_rst_tick", 32'(bus.tick_o), 32'd1);
        step(1);
        chk("post_rst_timeout_e5", 32'(bus.timeout), 32'd0);
        step(1);
        chk("post_rst_timeout_e6", 32'(bus.timeout), 32'hFF);
        chk("post_rst_exp_all", 32'(bus.expired_p), 32'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
